// File: rtl/imem_access_ctrl_if.sv
// Bundle of fetch, loader and memory-side signals shared by the instruction memory controller.
// The slave modport is the controller's view; master is the view of the surrounding requesters/memory.
interface imem_access_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              ld_req;
  logic              ld_we;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_done;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [31:0]       ld_rdata;

  logic              core_hold;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_done, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, core_hold,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_done, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, core_hold,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_access_ctrl.sv
// Single-port instruction memory arbiter: loader owns the memory during BOOT; in RUN fetch has
// priority, with a starvation counter guaranteeing the loader a slot.
module imem_access_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int STARVE_LIM = 4,
  parameter bit BOOT_EN    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  imem_access_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  typedef enum logic {S_BOOT, S_RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_starve;
  logic              r_if_pend;
  logic              r_ld_pend;
  logic              r_oor;

  logic              w_if_gnt;
  logic              w_ld_gnt;
  logic              w_grant;
  logic              w_oor;
  logic [31:2]       w_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= BOOT_EN ? S_BOOT : S_RUN;
    else     r_state <= w_state_nxt;
  end

  // Grants are gated by rst so every output sits at its reset value while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_gnt    = 1'b0;
    w_if_gnt    = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_ld_gnt = bus.ld_req;
        if (bus.ld_done) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_ld_gnt = bus.ld_req & (~bus.if_req | (r_starve == LIM));
        w_if_gnt = bus.if_req & ~w_ld_gnt;
      end
      default: w_state_nxt = r_state;
    endcase
    if (rst) begin
      w_ld_gnt = 1'b0;
      w_if_gnt = 1'b0;
    end
  end

  assign w_grant = w_if_gnt | w_ld_gnt;
  assign w_addr  = w_ld_gnt ? bus.ld_addr[31:2] : bus.if_addr[31:2];
  assign w_oor   = |w_addr[31:ADDR_W+2];

  assign bus.if_gnt    = w_if_gnt;
  assign bus.ld_gnt    = w_ld_gnt;
  assign bus.core_hold = (r_state == S_BOOT);
  assign bus.mem_en    = w_grant & ~w_oor;
  assign bus.mem_we    = w_ld_gnt & bus.ld_we & ~w_oor;
  assign bus.mem_addr  = w_grant ? w_addr[ADDR_W+1:2] : '0;
  assign bus.mem_wdata = w_ld_gnt ? bus.ld_wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (r_state == S_RUN) begin
      if (w_ld_gnt)                          r_starve <= '0;
      else if (bus.ld_req && r_starve != LIM) r_starve <= r_starve + 1'b1;
    end
  end

  // Return owner is latched per grant so alternating owners never see each other's data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_pend <= 1'b0;
      r_ld_pend <= 1'b0;
      r_oor     <= 1'b0;
    end else begin
      r_if_pend <= w_if_gnt;
      r_ld_pend <= w_ld_gnt & ~bus.ld_we;
      r_oor     <= w_oor;
    end
  end

  assign bus.if_rvalid = r_if_pend;
  assign bus.ld_rvalid = r_ld_pend;
  assign bus.if_rdata  = (r_if_pend && !r_oor) ? bus.mem_rdata : '0;
  assign bus.ld_rdata  = (r_ld_pend && !r_oor) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed plus randomized bench for imem_access_ctrl against a behavioural arbitration/memory model.
module tb_imem_access_ctrl;
  localparam int AW  = 10;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_access_ctrl_if #(.ADDR_W(AW)) bus ();

  imem_access_ctrl #(.ADDR_W(AW), .STARVE_LIM(LIM), .BOOT_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory environment; returns garbage on cycles with no read so ungated rdata is visible.
  logic [31:0] mem [1<<AW];
  logic [31:0] rdata_q;
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) rdata_q <= mem[bus.mem_addr];
    else                           rdata_q <= $urandom;
  end
  assign bus.mem_rdata = rdata_q;

  int checks   = 0;
  int failures = 0;

  bit          m_boot;
  int          m_starve;
  bit          m_if_rv, m_ld_rv;
  logic [31:0] m_if_d, m_ld_d;
  logic [31:0] ref_mem [1<<AW];
  logic        g_if, g_ld;

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> (AW + 2)) == 32'd0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << AW) - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot   = 1'b1;
    m_starve = 0;
    m_if_rv  = 1'b0;
    m_ld_rv  = 1'b0;
    m_if_d   = '0;
    m_ld_d   = '0;
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+3, advance the model at the edge.
  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic lr, input logic lw, input logic [31:0] la,
                      input logic [31:0] lwd, input logic ld);
    bit          e_ld, e_if, e_en, e_we, rng;
    logic [31:0] a;
    rst = r;
    bus.if_req = ir; bus.if_addr = ia;
    bus.ld_req = lr; bus.ld_we = lw; bus.ld_addr = la; bus.ld_wdata = lwd; bus.ld_done = ld;
    if (r) model_reset();
    #2;
    e_ld = !r && lr && (m_boot || !ir || m_starve == LIM);
    e_if = !r && !m_boot && ir && !e_ld;
    a    = e_ld ? la : ia;
    rng  = in_rng(a);
    e_en = (e_ld || e_if) && rng;
    e_we = e_ld && lw && rng;
    g_if = bus.if_gnt;
    g_ld = bus.ld_gnt;
    chk("if_gnt", {31'd0, bus.if_gnt}, {31'd0, e_if});
    chk("ld_gnt", {31'd0, bus.ld_gnt}, {31'd0, e_ld});
    chk("core_hold", {31'd0, bus.core_hold}, {31'd0, m_boot});
    chk("mem_en", {31'd0, bus.mem_en}, {31'd0, e_en});
    chk("mem_we", {31'd0, bus.mem_we}, {31'd0, e_we});
    if (e_en) chk("mem_addr", 32'(bus.mem_addr), 32'(widx(a)));
    if (e_we) chk("mem_wdata", bus.mem_wdata, lwd);
    chk("if_rvalid", {31'd0, bus.if_rvalid}, {31'd0, m_if_rv});
    chk("if_rdata", bus.if_rdata, m_if_rv ? m_if_d : 32'd0);
    chk("ld_rvalid", {31'd0, bus.ld_rvalid}, {31'd0, m_ld_rv});
    chk("ld_rdata", bus.ld_rdata, m_ld_rv ? m_ld_d : 32'd0);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      m_if_rv = e_if;
      m_if_d  = rng ? ref_mem[widx(a)] : 32'd0;
      m_ld_rv = e_ld && !lw;
      m_ld_d  = rng ? ref_mem[widx(a)] : 32'd0;
      if (e_we) ref_mem[widx(a)] = lwd;
      if (!m_boot) begin
        if (e_ld)                      m_starve = 0;
        else if (lr && m_starve < LIM) m_starve++;
      end
      if (m_boot && ld) m_boot = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] v, ia, la;
    bit r, ir, lr, lw, ld;
    for (int i = 0; i < (1 << AW); i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.ld_req = 0; bus.ld_we = 0;
    bus.ld_addr = 0; bus.ld_wdata = 0; bus.ld_done = 0;
    model_reset();
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h4, 1, 1, 32'h8, 32'h1234, 0);
    idle();

    // Fetch held during BOOT is never granted
    repeat (5) step(0, 1, 32'h4, 0, 0, 0, 0, 0);
    // Boot load, then done pulse; fetch wins the first RUN cycle
    step(0, 1, 32'h4, 1, 1, 32'h0, 32'h00A00093, 0);
    step(0, 1, 32'h4, 1, 1, 32'h4, 32'h01400113, 0);
    step(0, 1, 32'h4, 0, 0, 0, 0, 1);
    chk("t1_core_hold_fall", {31'd0, bus.core_hold}, 32'd0);
    step(0, 1, 32'h4, 0, 0, 0, 0, 0);
    chk("t2_first_run_gnt", {31'd0, g_if}, 32'd1);
    chk("t1_fetch_rdata", bus.if_rdata, 32'h01400113);
    idle();

    // Contention: F,F,F,F,L repeating
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 32'(k * 4), 1, 0, 32'h8, 0, 0);
      chk("t3_pattern", {31'd0, g_ld}, (k % 5 == 4) ? 32'd1 : 32'd0);
    end

    // Out-of-range fetch and dropped out-of-range write
    step(0, 1, 32'h0000_1000, 0, 0, 0, 0, 0);
    chk("t4_oor_rdata", bus.if_rdata, 32'd0);
    step(0, 0, 0, 1, 1, 32'h0000_1000, 32'hFFFF_FFFF, 0);
    step(0, 1, 32'h0, 0, 0, 0, 0, 0);
    chk("t4_mem_unchanged", bus.if_rdata, 32'h00A00093);

    // Loader readback in RUN
    step(0, 0, 0, 1, 1, 32'h8, 32'hDEAD_BEEF, 0);
    step(0, 0, 0, 1, 0, 32'h8, 0, 0);
    chk("t6_ld_rdata", bus.ld_rdata, 32'hDEAD_BEEF);

    // Reset while a fetch return is pending
    step(0, 1, 32'h4, 0, 0, 0, 0, 0);
    step(1, 1, 32'h4, 1, 0, 32'h4, 0, 0);
    step(1, 1, 32'h4, 0, 0, 0, 0, 0);
    idle();
    chk("t5_boot_after_reset", {31'd0, bus.core_hold}, 32'd1);

    // Randomized traffic with occasional done pulses and resets
    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 24) == 0);
      ir = ($urandom_range(0, 9) < 6);
      lr = ($urandom_range(0, 1) == 1);
      lw = ($urandom_range(0, 1) == 1);
      ia = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 4095));
      la = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 4095));
      step(r, ir, ia, lr, lw, la, $urandom, ld);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
